// File: rtl/crc8_calculator.sv
// Byte-serial CRC-8 (MSB-first, no reflection, no final XOR) for the UART-AXI4 bridge framing.
// Folds one byte per enabled clock. crc_final previews the result, including the byte currently presented.
module crc8_calculator #(
    parameter logic [7:0] POLY = 8'h07,
    parameter logic [7:0] INIT = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       crc_enable,
    input  logic [7:0] data_in,
    input  logic       crc_reset,
    output logic [7:0] crc_out,
    output logic [7:0] crc_final
);

    logic [7:0] crc_q;
    logic [7:0] crc_d;
    logic [7:0] crc_next_byte;

    // The loop is fully unrolled into an XOR network, so a whole byte is folded in one cycle.
    function automatic logic [7:0] crc8_next(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] t;
        t = c ^ d;
        for (int i = 0; i < 8; i++) begin
            if (t[7]) begin
                t = {t[6:0], 1'b0} ^ POLY;
            end else begin
                t = {t[6:0], 1'b0};
            end
        end
        return t;
    endfunction

    always_comb begin
        crc_next_byte = crc8_next(crc_q, data_in);
    end

    // A clear wins over a byte in the same cycle, so that byte is dropped.
    always_comb begin
        crc_d = crc_q;
        if (crc_reset) begin
            crc_d = INIT;
        end else if (crc_enable) begin
            crc_d = crc_next_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            crc_q <= INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_out   = crc_q;
    assign crc_final = crc_enable ? crc_next_byte : crc_q;

endmodule

// File: tb/tb_crc8_calculator.sv
// Directed and randomised checks of crc8_calculator against hand-computed CRC-8/0x07 values.
// The reference model folds the data in one bit at a time.
module tb_crc8_calculator;

    logic       clk;
    logic       rst;
    logic       crc_enable;
    logic [7:0] data_in;
    logic       crc_reset;
    logic [7:0] crc_out;
    logic [7:0] crc_final;

    int checks = 0;
    int errors = 0;

    crc8_calculator dut (
        .clk       (clk),
        .rst       (rst),
        .crc_enable(crc_enable),
        .data_in   (data_in),
        .crc_reset (crc_reset),
        .crc_out   (crc_out),
        .crc_final (crc_final)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %02h exp %02h", tag, got, exp);
        end
    endtask

    // Shifts in one data bit per step. The DUT instead XORs the whole byte into the register up front.
    function automatic logic [7:0] model_next(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        logic       fb;
        r = c;
        for (int b = 7; b >= 0; b--) begin
            fb = r[7] ^ d[b];
            r  = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic [7:0] d, input logic clr);
        crc_enable = en;
        data_in    = d;
        crc_reset  = clr;
        #1;
    endtask

    task automatic byte_test(input string tag, input logic [7:0] d, input logic [7:0] exp);
        drive(1'b0, 8'h5A, 1'b1);
        tick();
        drive(1'b1, d, 1'b0);
        check_eq({tag, "_final"}, crc_final, exp);
        tick();
        drive(1'b0, 8'hC3, 1'b0);
        check_eq({tag, "_out"}, crc_out, exp);
        check_eq({tag, "_final_idle"}, crc_final, exp);
    endtask

    logic [7:0] str [9];
    logic [7:0] m;
    logic [7:0] exp_mid;
    logic       r_en, r_clr, r_rst;
    logic [7:0] r_d;

    initial begin
        str = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        rst = 1'b1;
        crc_enable = 1'b0;
        data_in = 8'h00;
        crc_reset = 1'b0;

        tick();
        tick();
        check_eq("reset_out", crc_out, 8'h00);
        check_eq("reset_final", crc_final, 8'h00);
        rst = 1'b0;

        byte_test("b01", 8'h01, 8'h07);
        byte_test("b80", 8'h80, 8'h89);
        byte_test("bFF", 8'hFF, 8'hF3);
        byte_test("b00", 8'h00, 8'h00);

        // Back-to-back check string.
        drive(1'b0, 8'h00, 1'b1);
        tick();
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, str[i], 1'b0);
            if (i == 8) check_eq("str_final", crc_final, 8'hF4);
            tick();
        end
        drive(1'b0, 8'h00, 1'b0);
        check_eq("str_out", crc_out, 8'hF4);

        // Same string with idle gaps and junk data while disabled.
        drive(1'b0, 8'h00, 1'b1);
        tick();
        for (int i = 0; i < 9; i++) begin
            for (int g = $urandom_range(0, 3); g > 0; g--) begin
                drive(1'b0, 8'($urandom), 1'b0);
                tick();
            end
            drive(1'b1, str[i], 1'b0);
            tick();
        end
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, 8'($urandom), 1'b0);
            check_eq("gap_hold", crc_out, 8'hF4);
            tick();
        end

        // crc_reset beats enable. crc_final still previews the byte.
        drive(1'b0, 8'h00, 1'b1);
        tick();
        drive(1'b1, 8'h31, 1'b0);
        tick();
        drive(1'b1, 8'h32, 1'b0);
        tick();
        exp_mid = model_next(model_next(model_next(8'h00, 8'h31), 8'h32), 8'h33);
        drive(1'b1, 8'h33, 1'b1);
        check_eq("clr_prio_final", crc_final, exp_mid);
        tick();
        drive(1'b1, 8'h01, 1'b0);
        check_eq("clr_prio_out", crc_out, 8'h00);
        check_eq("clr_restart_final", crc_final, 8'h07);
        tick();
        drive(1'b0, 8'h00, 1'b0);
        check_eq("clr_restart_out", crc_out, 8'h07);

        // rst in the middle of a sequence.
        drive(1'b1, 8'h31, 1'b0);
        tick();
        drive(1'b1, 8'h32, 1'b0);
        tick();
        rst = 1'b1;
        drive(1'b1, 8'h33, 1'b0);
        tick();
        rst = 1'b0;
        drive(1'b1, 8'h01, 1'b0);
        check_eq("rst_mid_out", crc_out, 8'h00);
        tick();
        drive(1'b0, 8'h00, 1'b0);
        check_eq("rst_restart_out", crc_out, 8'h07);

        // Frame usage: status 0x00 then cmd 0x01.
        drive(1'b0, 8'h00, 1'b1);
        tick();
        drive(1'b1, 8'h00, 1'b0);
        tick();
        drive(1'b1, 8'h01, 1'b0);
        tick();
        drive(1'b0, 8'h00, 1'b0);
        check_eq("frame_out", crc_out, 8'h07);

        // Random streams with random enable, clear and reset, compared every cycle.
        rst = 1'b1;
        drive(1'b0, 8'h00, 1'b0);
        tick();
        rst = 1'b0;
        m = 8'h00;
        for (int n = 0; n < 1000; n++) begin
            r_en  = ($urandom_range(0, 3) != 0);
            r_clr = ($urandom_range(0, 15) == 0);
            r_rst = ($urandom_range(0, 63) == 0);
            r_d   = 8'($urandom);
            rst   = r_rst;
            drive(r_en, r_d, r_clr);
            check_eq("rand_out", crc_out, m);
            check_eq("rand_final", crc_final, r_en ? model_next(m, r_d) : m);
            tick();
            if (r_rst || r_clr) m = 8'h00;
            else if (r_en) m = model_next(m, r_d);
        end
        rst = 1'b0;
        drive(1'b0, 8'h00, 1'b0);
        check_eq("rand_last_out", crc_out, m);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/crc8_calculator.md
Name: crc8_calculator

Overview:
- Byte-serial CRC-8 engine for the UART-AXI4 bridge protocol.
- Generator polynomial 0x07 (x^8+x^2+x+1), initial value 0x00, MSB-first, no reflection, no final XOR.
- Frame builder/parser feed it one byte per enabled cycle and read the registered checksum the cycle after the last byte.
- `crc_final` gives the same result combinationally, including the byte currently presented.

Parameters:
- POLY, 8'h07, generator polynomial; the x^8 term is implicit.
- INIT, 8'h00, value loaded on reset and on crc_reset.

Ports:
- clk  input  1  rising-edge system clock.
- rst  input  1  synchronous, active-high reset.
- crc_enable  input  1  fold data_in into the CRC this cycle.
- data_in  input  8  byte to accumulate; only sampled when crc_enable=1.
- crc_reset  input  1  synchronous clear of the running CRC to INIT.
- crc_out  output  8  registered running CRC of all bytes accepted since the last clear.
- crc_final  output  8  combinational CRC including data_in when crc_enable=1; otherwise equals crc_out.

Behaviour:
- Single register crc_q[7:0]; crc_out = crc_q.
- Reset value: crc_q = INIT (0x00), so crc_out = 0x00 and crc_final = 0x00 while enable is low.
- Priority at each posedge clk, highest first:
  - rst=1: crc_q <= INIT.
  - else crc_reset=1: crc_q <= INIT. A byte presented with crc_enable in the same cycle is discarded.
  - else crc_enable=1: crc_q <= next(crc_q, data_in).
  - else crc_q holds.
- next(c, d) algorithm:
  - t = c XOR d.
  - Repeat 8 times: if t[7] then t = (t<<1) XOR POLY, else t = t<<1, truncated to 8 bits.
  - Result is t.
  - Must be implemented as a single-cycle combinational function (unrolled loop or equivalent XOR network), not a multi-cycle shifter.
- Latency:
  - crc_out reflects a byte one clock after the cycle in which it was enabled.
  - crc_final reflects it in the same cycle.
- Throughput: one byte per clock, with no gaps required between enabled cycles.
- crc_final = crc_enable ? next(crc_q, data_in) : crc_q.
  - crc_reset does not alter crc_final within the cycle.
  - crc_final is purely combinational from crc_q, data_in and crc_enable.
- No internal byte counter, no frame state, no overflow condition; the CRC accumulates indefinitely until cleared.
- Reset or crc_reset mid-sequence discards all accumulated state; the next enabled byte starts from INIT.
- data_in is a don't-care when crc_enable=0, and must not affect crc_q.
- Holding crc_reset high for many cycles keeps crc_q at INIT. This is the intended idle usage by the frame builder.
- Outputs must never be X after the first reset cycle. No latches.

Test Plan:
- Reset: assert rst 2 cycles, enable=0 -> crc_out=0x00, crc_final=0x00.
- Single bytes, each preceded by a crc_reset cycle:
  - 0x01 -> crc_out=0x07 one cycle later.
  - 0x80 -> 0x89.
  - 0xFF -> 0xF3.
  - 0x00 -> 0x00.
  - For each, crc_final shows the value during the enable cycle.
- Check string: after crc_reset, feed ASCII "123456789" (0x31..0x39) on 9 consecutive enabled cycles -> crc_out=0xF4 the cycle after the last byte; crc_final=0xF4 during the 9th byte.
- Gaps/hold: feed the same string with random idle cycles and random data_in while enable=0 -> final crc_out still 0xF4, and it holds 0xF4 through 5 further idle cycles.
- Clear priority and mid-sequence reset:
  - After 0x31,0x32, assert crc_reset together with crc_enable and data_in=0x33 -> crc_out=0x00 next cycle. Then 0x01 alone -> 0x07.
  - Repeat with rst instead of crc_reset -> same result.
- Frame usage: after crc_reset, feed status 0x00 and cmd 0x01 -> crc_out=0x07.
- Randomised cross-check: 1000 random byte streams with random enable and reset patterns vs. a software model of POLY=0x07/INIT=0x00 -> crc_out and crc_final match every cycle.
